// File: rtl/decode_queue_if.sv
// Handshake bundle between fetch/decode producer, decode_queue and rename.
// master drives instructions and takes; slave is the queue.
interface decode_queue_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 64
);
    localparam int TW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush_i;
    logic [WIDTH-1:0]      in_valid_i;
    logic [WIDTH*32-1:0]   in_instr_i;
    logic [WIDTH*XLEN-1:0] in_pc_i;
    logic                  in_ready_o;
    logic [WIDTH-1:0]      out_valid_o;
    logic [WIDTH*26-1:0]   out_dec_o;
    logic [WIDTH*XLEN-1:0] out_pc_o;
    logic [WIDTH-1:0]      out_illegal_o;
    logic [TW-1:0]         out_take_i;
    logic [CW-1:0]         count_o;

    modport master (
        output flush_i, in_valid_i, in_instr_i, in_pc_i, out_take_i,
        input  in_ready_o, out_valid_o, out_dec_o, out_pc_o,
        input  out_illegal_o, count_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_instr_i, in_pc_i, out_take_i,
        output in_ready_o, out_valid_o, out_dec_o, out_pc_o,
        output out_illegal_o, count_o
    );
endinterface

// File: rtl/decode_queue.sv
// Multi-slot decode buffer: decodes up to WIDTH instructions into a circular
// queue. Define DECQ_RV64W_EN to accept the RV64 word-op opcodes.
package decode_queue_pkg;
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rs1_v;
        logic       rs2_v;
        logic       rd_v;
        logic [3:0] operation;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_csr;
    } instr_dec_t;
endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 64
) (
    input logic          clk,
    input logic          reset_n,
    decode_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(WIDTH + 1);

`ifdef DECQ_RV64W_EN
    localparam bit RV64W = 1'b1;
`else
    localparam bit RV64W = 1'b0;
`endif

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    instr_dec_t       dec [WIDTH];
    logic [WIDTH-1:0] ill;
    logic [TW-1:0]    n_in;
    logic [TW-1:0]    n_enq;
    logic [TW-1:0]    n_out;
    logic             enq;

    instr_dec_t       mem_dec [DEPTH];
    logic [XLEN-1:0]  mem_pc  [DEPTH];
    logic [DEPTH-1:0] mem_ill;

    always_comb begin
        logic [31:0] ins;
        logic [2:0]  f3;
        logic r, i, l, s, b, u, au, jal, jalr, p, r64, i64, ok;
        for (int k = 0; k < WIDTH; k++) begin
            ins  = q.in_instr_i[32*k +: 32];
            f3   = ins[14:12];
            r    = 1'b0; i   = 1'b0; l    = 1'b0; s = 1'b0;
            b    = 1'b0; u   = 1'b0; au   = 1'b0; jal = 1'b0;
            jalr = 1'b0; p   = 1'b0; r64  = 1'b0; i64 = 1'b0;
            case (ins[6:0])
                7'b0110011: r    = 1'b1;
                7'b0010011: i    = 1'b1;
                7'b0000011: l    = 1'b1;
                7'b0100011: s    = 1'b1;
                7'b1100011: b    = 1'b1;
                7'b0110111: u    = 1'b1;
                7'b0010111: au   = 1'b1;
                7'b1101111: jal  = 1'b1;
                7'b1100111: jalr = 1'b1;
                7'b1110011: p    = 1'b1;
                7'b0111011: r64  = RV64W;
                7'b0011011: i64  = RV64W;
                default: ;
            endcase
            ok = (ins[1:0] == 2'b11) &&
                 (r | i | l | s | b | u | au | jal | jalr | p | r64 | i64);
            ill[k] = !ok;
            dec[k] = '0;
            if (ok) begin
                dec[k].rs1   = ins[19:15];
                dec[k].rs2   = ins[24:20];
                dec[k].rd    = ins[11:7];
                dec[k].rs1_v = r | i | l | s | b | jalr | r64 | i64 |
                               (p && f3 != 3'd0 && !f3[2]);
                dec[k].rs2_v = r | s | b | r64;
                dec[k].rd_v  = (r | i | l | u | au | jal | jalr | r64 | i64 |
                                (p && f3 != 3'd0)) && (ins[11:7] != 5'd0);
                // bit 30 only distinguishes sub/sra-style variants
                dec[k].operation = {ins[30] & (r | r64 |
                                   ((i | i64) && f3 == 3'b101)), f3};
                dec[k].is_load   = l;
                dec[k].is_store  = s;
                dec[k].is_branch = b | jal | jalr;
                dec[k].is_csr    = p && f3 != 3'd0;
            end
        end
    end

    always_comb begin
        n_in = '0;
        for (int k = 0; k < WIDTH; k++) begin
            n_in = n_in + TW'(q.in_valid_i[k]);
        end
    end

    assign enq   = q.in_ready_o && !q.flush_i;
    assign n_enq = enq ? n_in : '0;

    always_ff @(posedge clk) begin
        if (enq) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (q.in_valid_i[k]) begin
                    mem_dec[PW'(wr_ptr + PW'(k))] <= dec[k];
                    mem_pc[PW'(wr_ptr + PW'(k))]  <= q.in_pc_i[XLEN*k +: XLEN];
                    mem_ill[PW'(wr_ptr + PW'(k))] <= ill[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (q.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(q.out_take_i);
            wr_ptr <= wr_ptr + PW'(n_enq);
            count  <= count + CW'(n_enq) - CW'(q.out_take_i);
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        n_out = '0;
        for (int k = 0; k < WIDTH; k++) begin
            idx = rd_ptr + PW'(k);
            q.out_valid_o[k]             = count > CW'(k);
            q.out_dec_o[26*k +: 26]      = mem_dec[idx];
            q.out_pc_o[XLEN*k +: XLEN]   = mem_pc[idx];
            q.out_illegal_o[k]           = mem_ill[idx];
            n_out = n_out + TW'(q.out_valid_o[k]);
        end
    end

    // ready depends on registered count only, never on this cycle's take
    assign q.in_ready_o = (DEPTH - int'(count)) >= WIDTH;
    assign q.count_o    = count;

    a_take_overrun : assert property (
        @(posedge clk) disable iff (!reset_n) q.out_take_i <= n_out
    );
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, decode, fill/wrap, flush,
// illegal opcodes and asynchronous reset.
module tb_decode_queue;
    localparam int WIDTH = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 64;

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] LW   = 32'h00832283;
    localparam logic [31:0] ADDW = 32'h002081BB;
    localparam logic [25:0] DEC_ADD =
        {5'd1, 5'd2, 5'd3, 3'b111, 4'b0000, 4'b0000};
    localparam logic [25:0] DEC_LW =
        {5'd6, 5'd8, 5'd5, 3'b101, 4'b0010, 4'b1000};
`ifdef DECQ_RV64W_EN
    localparam logic        ADDW_ILL = 1'b0;
    localparam logic [25:0] DEC_ADDW = DEC_ADD;
`else
    localparam logic        ADDW_ILL = 1'b1;
    localparam logic [25:0] DEC_ADDW = '0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    decode_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .XLEN(XLEN)) q ();

    decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (q)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drv(input logic [1:0] v, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [63:0] p0,
                       input logic [63:0] p1, input logic [1:0] take,
                       input logic fl);
        q.in_valid_i = v;
        q.in_instr_i = {i1, i0};
        q.in_pc_i    = {p1, p0};
        q.out_take_i = take;
        q.flush_i    = fl;
    endtask

    task automatic idle();
        drv(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 2'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] nin;
        logic [63:0] nout;
        logic        rdy;
        reset_n = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_count", 64'(q.count_o), 64'd0);
        chk("rst_valid", 64'(q.out_valid_o), 64'd0);
        chk("rst_ready", 64'(q.in_ready_o), 64'd1);
        reset_n = 1'b1;

        drv(2'b11, ADD, LW, 64'h100, 64'h104, 2'd0, 1'b0);
        step();
        idle();
        chk("dec_count", 64'(q.count_o), 64'd2);
        chk("dec_valid", 64'(q.out_valid_o), 64'd3);
        chk("dec_add", 64'(q.out_dec_o[25:0]), 64'(DEC_ADD));
        chk("dec_lw", 64'(q.out_dec_o[51:26]), 64'(DEC_LW));
        chk("dec_ill", 64'(q.out_illegal_o), 64'd0);
        chk("dec_pc0", q.out_pc_o[63:0], 64'h100);
        chk("dec_pc1", q.out_pc_o[127:64], 64'h104);
        drv(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 2'd2, 1'b0);
        step();
        chk("take_count", 64'(q.count_o), 64'd0);
        chk("take_valid", 64'(q.out_valid_o), 64'd0);

        drv(2'b11, 32'h0, ADDW, 64'h200, 64'h204, 2'd0, 1'b0);
        step();
        idle();
        chk("ill_flags", 64'(q.out_illegal_o), 64'({ADDW_ILL, 1'b1}));
        chk("ill_dec0", 64'(q.out_dec_o[25:0]), 64'd0);
        chk("addw_dec", 64'(q.out_dec_o[51:26]), 64'(DEC_ADDW));
        drv(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 2'd2, 1'b0);
        step();

        nin = 64'h1000;
        for (int c = 0; c < 4; c++) begin
            drv(2'b11, ADD, ADD, nin, nin + 64'd4, 2'd0, 1'b0);
            step();
            nin = nin + 64'd8;
            chk("fill_count", 64'(q.count_o), 64'((c + 1) * 2));
            chk("fill_ready", 64'(q.in_ready_o), (c < 3) ? 64'd1 : 64'd0);
        end

        nout = 64'h1000;
        for (int c = 0; c < 10; c++) begin
            chk("wrap_pc0", q.out_pc_o[63:0], nout);
            chk("wrap_pc1", q.out_pc_o[127:64], nout + 64'd4);
            rdy = q.in_ready_o;
            drv(2'b11, ADD, ADD, nin, nin + 64'd4, 2'd2, 1'b0);
            step();
            nout = nout + 64'd8;
            if (rdy) nin = nin + 64'd8;
            chk("wrap_count", 64'(q.count_o), 64'd6);
            chk("wrap_ready", 64'(q.in_ready_o), 64'd1);
        end

        drv(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 2'd0, 1'b1);
        step();
        chk("flush0_count", 64'(q.count_o), 64'd0);
        drv(2'b11, ADD, ADD, 64'h2000, 64'h2004, 2'd0, 1'b0);
        step();
        drv(2'b11, ADD, ADD, 64'h2008, 64'h200c, 2'd0, 1'b0);
        step();
        drv(2'b01, ADD, ADD, 64'h2010, 64'h2014, 2'd0, 1'b0);
        step();
        chk("pre_flush", 64'(q.count_o), 64'd5);
        drv(2'b11, ADD, ADD, 64'h2018, 64'h201c, 2'd1, 1'b1);
        step();
        idle();
        chk("flush_count", 64'(q.count_o), 64'd0);
        chk("flush_valid", 64'(q.out_valid_o), 64'd0);
        chk("flush_ready", 64'(q.in_ready_o), 64'd1);
        drv(2'b11, ADD, ADD, 64'h3000, 64'h3004, 2'd0, 1'b0);
        step();
        idle();
        chk("post_flush_pc", q.out_pc_o[63:0], 64'h3000);
        chk("post_flush_cnt", 64'(q.count_o), 64'd2);

        drv(2'b11, ADD, ADD, 64'h4000, 64'h4004, 2'd0, 1'b0);
        step();
        drv(2'b01, ADD, ADD, 64'h4008, 64'h400c, 2'd0, 1'b0);
        step();
        idle();
        chk("pre_arst", 64'(q.count_o), 64'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", 64'(q.count_o), 64'd0);
        chk("arst_valid", 64'(q.out_valid_o), 64'd0);
        chk("arst_ready", 64'(q.in_ready_o), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        drv(2'b11, LW, ADD, 64'h5000, 64'h5004, 2'd0, 1'b0);
        step();
        idle();
        chk("rel_pc0", q.out_pc_o[63:0], 64'h5000);
        chk("rel_dec0", 64'(q.out_dec_o[25:0]), 64'(DEC_LW));
        chk("rel_count", 64'(q.count_o), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
